// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the two-master Avalon bus arbiter.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_M0 = 2'd1,
    GRANT_M1 = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates an instruction-fetch master (m0) and a data master (m1) onto one Avalon slave port.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic [31:0] m0_address,
  input  logic [31:0] m0_writedata,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [3:0]  m0_byteenable,
  output logic [31:0] m0_readdata,
  output logic        m0_waitrequest,

  input  logic [31:0] m1_address,
  input  logic [31:0] m1_writedata,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [3:0]  m1_byteenable,
  output logic [31:0] m1_readdata,
  output logic        m1_waitrequest,

  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  arb_state_t state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       req0, req1;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= M1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    address        = '0;
    read           = 1'b0;
    write          = 1'b0;
    byteenable     = '0;
    writedata      = '0;
    m0_readdata    = '0;
    m1_readdata    = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (req0 && req1) begin
          if (FIXED_PRIORITY != 0) begin
            state_d = GRANT_M1;
          end else begin
            state_d = (last_grant_q == M1) ? GRANT_M0 : GRANT_M1;
          end
        end else if (req0) begin
          state_d = GRANT_M0;
        end else if (req1) begin
          state_d = GRANT_M1;
        end
      end

      GRANT_M0: begin
        address        = m0_address;
        write          = m0_write;
        // Write wins a simultaneous read/write so the slave never sees both.
        read           = m0_read & ~m0_write;
        byteenable     = m0_byteenable;
        writedata      = m0_writedata;
        m0_readdata    = readdata;
        m0_waitrequest = waitrequest;
        if (!req0) begin
          state_d = IDLE;
        end else if (!waitrequest) begin
          state_d      = IDLE;
          last_grant_d = M0;
        end
      end

      GRANT_M1: begin
        address        = m1_address;
        write          = m1_write;
        read           = m1_read & ~m1_write;
        byteenable     = m1_byteenable;
        writedata      = m1_writedata;
        m1_readdata    = readdata;
        m1_waitrequest = waitrequest;
        if (!req1) begin
          state_d = IDLE;
        end else if (!waitrequest) begin
          state_d      = IDLE;
          last_grant_d = M1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: round-robin and fixed-priority instances on shared stimulus.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [31:0] readdata;
  logic        waitrequest;

  logic [31:0] m0_readdata, m1_readdata, address, writedata;
  logic        m0_waitrequest, m1_waitrequest, read, write;
  logic [3:0]  byteenable;

  logic [31:0] fp_m0_readdata, fp_m1_readdata, fp_address, fp_writedata;
  logic        fp_m0_waitrequest, fp_m1_waitrequest, fp_read, fp_write;
  logic [3:0]  fp_byteenable;

  int tests = 0;
  int failed = 0;

  mem_bus_arbiter #(.FIXED_PRIORITY(0)) u_rr (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_read(m0_read),
    .m0_write(m0_write), .m0_byteenable(m0_byteenable), .m0_readdata(m0_readdata),
    .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_read(m1_read),
    .m1_write(m1_write), .m1_byteenable(m1_byteenable), .m1_readdata(m1_readdata),
    .m1_waitrequest(m1_waitrequest),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest)
  );

  mem_bus_arbiter #(.FIXED_PRIORITY(1)) u_fp (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_read(m0_read),
    .m0_write(m0_write), .m0_byteenable(m0_byteenable), .m0_readdata(fp_m0_readdata),
    .m0_waitrequest(fp_m0_waitrequest),
    .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_read(m1_read),
    .m1_write(m1_write), .m1_byteenable(m1_byteenable), .m1_readdata(fp_m1_readdata),
    .m1_waitrequest(fp_m1_waitrequest),
    .address(fp_address), .read(fp_read), .write(fp_write), .byteenable(fp_byteenable),
    .writedata(fp_writedata), .readdata(readdata), .waitrequest(waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle later, 1 time unit past the edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Slave read and write must never be asserted together.
  always @(negedge clk) begin
    if (!reset) begin
      tests++;
      assert (!(read && write) && !(fp_read && fp_write)) else begin
        failed++;
        $error("FAIL rw_exclusive observed=%b%b%b%b expected=no read&write pair",
               read, write, fp_read, fp_write);
      end
    end
  end

  initial begin
    reset = 1'b1;
    m0_address = '0; m0_writedata = '0; m0_read = 1'b0; m0_write = 1'b0; m0_byteenable = '0;
    m1_address = '0; m1_writedata = '0; m1_read = 1'b0; m1_write = 1'b0; m1_byteenable = '0;
    readdata = '0; waitrequest = 1'b0;

    #2;
    chk("reset_read", {31'b0, read}, 32'd0);
    chk("reset_write", {31'b0, write}, 32'd0);
    chk("reset_addr", address, 32'd0);
    chk("reset_m0_wait", {31'b0, m0_waitrequest}, 32'd1);
    chk("reset_m1_wait", {31'b0, m1_waitrequest}, 32'd1);

    @(negedge clk);
    reset = 1'b0;
    step();

    // Single m0 read, zero wait.
    m0_read = 1'b1; m0_address = 32'h0000_0010; m0_byteenable = 4'hF;
    readdata = 32'hCAFE_F00D; waitrequest = 1'b0;
    #1;
    chk("m0rd_idle_read", {31'b0, read}, 32'd0);
    chk("m0rd_idle_wait", {31'b0, m0_waitrequest}, 32'd1);
    chk("m0rd_idle_rdata", m0_readdata, 32'd0);
    step();
    chk("m0rd_gnt_read", {31'b0, read}, 32'd1);
    chk("m0rd_gnt_addr", address, 32'h0000_0010);
    chk("m0rd_gnt_be", {28'b0, byteenable}, 32'hF);
    chk("m0rd_gnt_wait", {31'b0, m0_waitrequest}, 32'd0);
    chk("m0rd_gnt_rdata", m0_readdata, 32'hCAFE_F00D);
    chk("m0rd_gnt_m1wait", {31'b0, m1_waitrequest}, 32'd1);
    chk("m0rd_gnt_m1rdata", m1_readdata, 32'd0);
    step();
    m0_read = 1'b0;
    #1;
    chk("m0rd_done_read", {31'b0, read}, 32'd0);
    chk("m0rd_done_wait", {31'b0, m0_waitrequest}, 32'd1);

    // Tie arbitration from a fresh reset.
    reset = 1'b1; #1; reset = 1'b0;
    step();
    m0_read = 1'b1; m0_address = 32'h0000_0100;
    m1_read = 1'b1; m1_address = 32'h0000_0200; m1_byteenable = 4'hF;
    step();
    chk("tie1_rr_addr", address, 32'h0000_0100);
    chk("tie1_rr_m1wait", {31'b0, m1_waitrequest}, 32'd1);
    chk("tie1_fp_addr", fp_address, 32'h0000_0200);
    step();
    chk("tie1_idle_addr", address, 32'd0);
    chk("tie1_idle_read", {31'b0, read}, 32'd0);
    step();
    chk("tie2_rr_addr", address, 32'h0000_0200);
    chk("tie2_fp_addr", fp_address, 32'h0000_0200);
    step();
    step();
    chk("tie3_rr_addr", address, 32'h0000_0100);
    chk("tie3_fp_addr", fp_address, 32'h0000_0200);
    m0_read = 1'b0; m1_read = 1'b0;
    step();
    step();

    // m1 write with three wait cycles.
    m1_write = 1'b1; m1_address = 32'h0000_1000; m1_writedata = 32'hDEAD_BEEF;
    m1_byteenable = 4'b1111; waitrequest = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) waitrequest = 1'b0;
      #1;
      chk("m1wr_write", {31'b0, write}, 32'd1);
      chk("m1wr_read", {31'b0, read}, 32'd0);
      chk("m1wr_addr", address, 32'h0000_1000);
      chk("m1wr_data", writedata, 32'hDEAD_BEEF);
      chk("m1wr_be", {28'b0, byteenable}, 32'hF);
      chk("m1wr_m1wait", {31'b0, m1_waitrequest}, (i == 3) ? 32'd0 : 32'd1);
      chk("m1wr_m0wait", {31'b0, m0_waitrequest}, 32'd1);
      step();
    end
    m1_write = 1'b0;
    #1;
    chk("m1wr_done_write", {31'b0, write}, 32'd0);
    chk("m1wr_done_m1wait", {31'b0, m1_waitrequest}, 32'd1);
    step();

    // Reset mid-transfer while m1 is granted.
    m1_read = 1'b1; m1_address = 32'h0000_2000; waitrequest = 1'b1;
    step();
    chk("rst_pre_read", {31'b0, read}, 32'd1);
    chk("rst_pre_addr", address, 32'h0000_2000);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_read", {31'b0, read}, 32'd0);
    chk("rst_mid_write", {31'b0, write}, 32'd0);
    chk("rst_mid_addr", address, 32'd0);
    chk("rst_mid_m1wait", {31'b0, m1_waitrequest}, 32'd1);
    m0_read = 1'b1; m0_address = 32'h0000_3000; waitrequest = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("rst_tie_rr_addr", address, 32'h0000_3000);
    chk("rst_tie_fp_addr", fp_address, 32'h0000_2000);
    m0_read = 1'b0; m1_read = 1'b0;
    step();
    step();

    // m0 read and write together: write wins.
    m0_read = 1'b1; m0_write = 1'b1; m0_address = 32'h0000_0040; m0_writedata = 32'h1234_5678;
    step();
    chk("rw_write", {31'b0, write}, 32'd1);
    chk("rw_read", {31'b0, read}, 32'd0);
    chk("rw_data", writedata, 32'h1234_5678);
    m0_read = 1'b0; m0_write = 1'b0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter FIXED_PRIORITY, default 0, meaning 0 = round-robin between m0 and m1, 1 = m1 always wins a contended arbitration.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 m0_address/m0_writedata  input  32 each  instruction-fetch master address and write data.
REQ-005 m0_read, m0_write  input  1 each; m0_byteenable  input  4  instruction-fetch master request strobes.
REQ-006 m0_readdata  output  32; m0_waitrequest  output  1  instruction-fetch master return path.
REQ-007 m1_address/m1_writedata  input  32; m1_read, m1_write  input  1; m1_byteenable  input  4  data master request.
REQ-008 m1_readdata  output  32; m1_waitrequest  output  1  data master return path.
REQ-009 address  output  32; read, write  output  1; byteenable  output  4; writedata  output  32  shared Avalon slave port.
REQ-010 readdata  input  32; waitrequest  input  1  shared slave response.

Function
REQ-011 The FSM SHALL have states IDLE, GRANT_M0 and GRANT_M1, held in a registered state variable.
REQ-012 A master requests when its read or write is high; in IDLE a single requester SHALL move the FSM to its GRANT state at the next edge.
REQ-013 In IDLE with both requesting, FIXED_PRIORITY=1 SHALL grant m1; FIXED_PRIORITY=0 SHALL grant the master not granted last, with last_grant resetting to m1 so m0 wins the first tie.
REQ-014 In IDLE, slave read, write and byteenable SHALL be 0, address and writedata SHALL be 0, and both m*_waitrequest SHALL be 1.
REQ-015 In GRANT_Mx, the slave outputs SHALL equal master x inputs combinationally and mx_waitrequest SHALL equal slave waitrequest.
REQ-016 In GRANT_Mx, the non-granted master's waitrequest SHALL be 1.
REQ-017 mx_readdata SHALL equal slave readdata while GRANT_Mx, else 0.
REQ-018 A transfer completes on a rising edge where the granted master requests and slave waitrequest is 0; the FSM SHALL then return to IDLE and last_grant SHALL update.
REQ-019 If the granted master drops its request before completion, the FSM SHALL return to IDLE at the next edge without updating last_grant.
REQ-020 If the granted master asserts read and write together, the arbiter SHALL forward write and drive slave read to 0.
REQ-021 Slave read and write SHALL never both be 1 in any cycle.
REQ-022 Arbitration latency SHALL be exactly one cycle (request in IDLE, grant on the next edge); a zero-wait transfer therefore occupies 2 cycles and back-to-back transfers alternate with IDLE.
REQ-023 Waitrequest from the slave of any length SHALL hold the grant with all forwarded signals stable.

Reset
REQ-024 Reset SHALL asynchronously force state IDLE and last_grant to m1, immediately giving all REQ-014 output values, including mid-transfer.
REQ-025 After reset deasserts, the first arbitration SHALL occur on the first rising edge with reset low.

Structure
REQ-026 A shared package SHALL hold the state enum typedef (IDLE, GRANT_M0, GRANT_M1) and master index constants M0=0, M1=1.
REQ-027 The block SHALL be a single module with no sub-modules: one sequential process (state, last_grant) and one combinational mux/next-state process.

Verification
REQ-028 m0 read 0x00000010 alone, slave waitrequest 0 -> grant next edge; m0_readdata=slave readdata; back to IDLE after 2 cycles total.
REQ-029 m0 and m1 both request from IDLE after reset with FIXED_PRIORITY=0 -> m0 granted first, then m1; repeat the tie -> m0 first again (alternation); FIXED_PRIORITY=1 -> m1 first every time.
REQ-030 m1 write 0xDEADBEEF to 0x00001000, byteenable 4'b1111, slave waitrequest high 3 cycles -> write held stable 4 cycles, m0_waitrequest=1 throughout, IDLE after completion.
REQ-031 Reset asserted mid-transfer while in GRANT_M1 -> read/write drop to 0 in the same time step without a clock edge; m0 wins the first tie after release.
REQ-032 m0 asserts read and write together -> slave write=1, read=0; a check on every cycle confirms read&&write is never 1.
